// File: rtl/det_pkg.sv
// +--------------------------------------------------------------------+
// | det_pkg : shared state encoding and defaults for det_window_counter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package det_pkg;

  localparam int DET_WINDOW = 16;
  localparam int DET_CNT_W  = 8;
  localparam int DET_THRESH = 3;
  localparam int DET_WIN_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    REPORT = 2'b10
  } det_state_t;

endpackage

`default_nettype wire

// File: rtl/det_window_counter_sat_counter.sv
// +--------------------------------------------------------------------+
// | sat_counter : CNT_W-bit saturating up-counter with clear/enable     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module sat_counter
  import det_pkg::*;
#(
  parameter int CNT_W = DET_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_sat_nxt;

  // Outputs look ahead by one cycle so a caller can capture the total
  // including the increment requested in the current cycle.
  always_comb begin
    w_count_nxt = r_count;
    w_sat_nxt   = r_sat;
    if (i_en) begin
      if (r_count == '1) begin
        w_sat_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  assign o_count = w_count_nxt;
  assign o_sat   = w_sat_nxt;

endmodule

`default_nettype wire

// File: rtl/det_window_counter.sv
// +--------------------------------------------------------------------+
// | det_window_counter : counts detector hits over a WINDOW-cycle span  |
// | Option macro: AUTO_RESTART_EN (re-arm window after handshake)       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module det_window_counter
  import det_pkg::*;
#(
  parameter int WINDOW = DET_WINDOW,
  parameter int CNT_W  = DET_CNT_W,
  parameter int THRESH = DET_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             det_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] result,
  output logic             alarm,
  output logic             sat
);

  localparam logic [DET_WIN_W-1:0] c_WIN_LOAD = DET_WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]     c_THRESH   = CNT_W'(THRESH);

  det_state_t           r_state;
  det_state_t           w_state_nxt;
  logic [DET_WIN_W-1:0] r_win;
  logic                 w_clr;
  logic                 w_en;
  logic                 w_last;
  logic [CNT_W-1:0]     w_cnt;
  logic                 w_cnt_sat;
  logic [CNT_W-1:0]     r_result;
  logic                 r_alarm;
  logic                 r_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      RUN: begin
        w_en = det_in;
        if (r_win == '0) begin
          w_last      = 1'b1;
          w_state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
`ifdef AUTO_RESTART_EN
          w_state_nxt = RUN;
          w_clr       = 1'b1;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win <= '0;
    end else if (w_clr) begin
      r_win <= c_WIN_LOAD;
    end else if (r_state == RUN && r_win != '0) begin
      r_win <= r_win - DET_WIN_W'(1);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_evt_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_cnt),
    .o_sat   (w_cnt_sat)
  );

  // Captured on the last window cycle so that cycle's sample is included.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_alarm  <= 1'b0;
      r_sat    <= 1'b0;
    end else if (w_last) begin
      r_result <= w_cnt;
      r_alarm  <= (w_cnt >= c_THRESH);
      r_sat    <= w_cnt_sat;
    end
  end

  assign busy      = (r_state == RUN);
  assign res_valid = (r_state == REPORT);
  assign result    = r_result;
  assign alarm     = r_alarm;
  assign sat       = r_sat;

endmodule

`default_nettype wire
